// File: rtl/seg7_reader.sv
// Decodes a seven-segment bus back to a hex digit once the pattern has been steady for STABLE_CYCLES samples.
// Latency: a pattern first sampled at edge k is accepted at edge k + STABLE_CYCLES - 1; outputs are registered.
// Backpressure: one-deep output register; a digit accepted while the register is still held is dropped and flags overrun.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         segments,
    output logic [3:0]         digit,
    output logic               digit_valid,
    input  logic               digit_ready,
    output logic               blank,
    output logic               pattern_error,
    output logic               overrun,
    output logic [COUNT_W-1:0] digit_count
);

    localparam logic [7:0]         STABLE    = 8'(STABLE_CYCLES);
    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [6:0] s_q;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       same;
    logic       accept;
    logic       pat_blank;
    logic       pat_legal;
    logic [3:0] pat_digit;

    // Map a segment pattern to {legal, digit}; anything outside the hex font is illegal.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        r = 5'h00;
        case (p)
            7'h3F: r = 5'h10;
            7'h06: r = 5'h11;
            7'h5B: r = 5'h12;
            7'h4F: r = 5'h13;
            7'h66: r = 5'h14;
            7'h6D: r = 5'h15;
            7'h7D: r = 5'h16;
            7'h07: r = 5'h17;
            7'h7F: r = 5'h18;
            7'h6F: r = 5'h19;
            7'h77: r = 5'h1A;
            7'h7C: r = 5'h1B;
            7'h39: r = 5'h1C;
            7'h5E: r = 5'h1D;
            7'h79: r = 5'h1E;
            7'h71: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Run-length of identical samples, acceptance and next state.
    // Acceptance takes priority over the change-forces-SETTLE rule so that,
    // with STABLE_CYCLES = 1, an accepted change locks instead of repeating.
    always_comb begin
        same       = (segments == s_q);
        cnt_next   = 8'd1;
        state_next = state;
        if (cnt != 8'd0 && same) begin
            cnt_next = (cnt >= STABLE) ? STABLE : cnt + 8'd1;
        end
        accept = (state == SETTLE) && (cnt_next == STABLE);
        if (accept) begin
            state_next = LOCKED;
        end else if (!same) begin
            state_next = SETTLE;
        end
        pat_blank = (segments == 7'h00);
        {pat_legal, pat_digit} = decode(segments);
    end

    // Sampler, run counter and FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETTLE;
            s_q   <= 7'h00;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            s_q   <= segments;
            cnt   <= cnt_next;
        end
    end

    // Output register, handshake, status flags and delivered-digit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit         <= 4'h0;
            digit_valid   <= 1'b0;
            blank         <= 1'b0;
            pattern_error <= 1'b0;
            overrun       <= 1'b0;
            digit_count   <= '0;
        end else begin
            pattern_error <= 1'b0;
            if (digit_valid && digit_ready) begin
                digit_valid <= 1'b0;
            end
            if (accept) begin
                if (pat_blank) begin
                    blank <= 1'b1;
                end else if (pat_legal) begin
                    blank <= 1'b0;
                    if (!digit_valid || digit_ready) begin
                        digit       <= pat_digit;
                        digit_valid <= 1'b1;
                        digit_count <= digit_count + COUNT_ONE;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    blank         <= 1'b0;
                    pattern_error <= 1'b1;
                end
            end
        end
    end

endmodule
